// File: rtl/axis_frame_packer_if.sv
// axis_frame_packer_if
//   AXI4-Stream bus between the frame packer and the S2MM DMA.
//   tdata  : 32-bit output beat
//   tvalid : beat valid
//   tlast  : last beat of a frame
//   tready : sink ready
//   master : packer side (drives tdata/tvalid/tlast, samples tready)
//   slave  : DMA side
interface axis_frame_packer_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_frame_packer.sv
// axis_frame_packer
//   Buffers a valid-only pixel stream (no backpressure) in a small FIFO and
//   re-issues it as an AXI4-Stream master with TLAST on the last pixel of
//   each frame.
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   enable_i      : 1 = accept input pixels (output drains regardless)
//   in_pixel_i    : pixel from the dehazing core
//   in_valid_i    : in_pixel_i valid this cycle
//   m_axis        : AXI4-Stream master bus (tdata/tvalid/tlast/tready)
//   fill_level_o  : entries held, including the beat on the bus
//   overflow_o    : sticky, a pixel was dropped since reset
//   frame_done_o  : one-cycle pulse after the TLAST beat handshakes
module axis_frame_packer #(
  parameter int DATA_W     = 24,
  parameter int IMG_W      = 512,
  parameter int IMG_H      = 512,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable_i,
  input  logic [DATA_W-1:0]             in_pixel_i,
  input  logic                          in_valid_i,
  axis_frame_packer_if.master           m_axis,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level_o,
  output logic                          overflow_o,
  output logic                          frame_done_o
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;
  localparam int NPIX = IMG_W * IMG_H;
  localparam int CW   = (NPIX > 1) ? $clog2(NPIX) : 1;

  // Storage is a register array; the head entry is read straight from a
  // register, so the bus outputs depend only on state, never on tready.
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] cnt_q,    cnt_d;
  logic [CW-1:0] beat_q,   beat_d;
  logic          ovf_q,    ovf_d;
  logic          done_q,   done_d;

  logic tvalid, full, acc, push, pop, drop, is_last;

  assign tvalid  = (cnt_q != '0);
  assign full    = (cnt_q == LW'(FIFO_DEPTH));
  assign pop     = tvalid & m_axis.tready;
  assign acc     = in_valid_i & enable_i;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts.
  assign push    = acc & (!full | pop);
  assign drop    = acc & full & !pop;
  assign is_last = (beat_q == CW'(NPIX - 1));

  always_comb begin
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    beat_d   = beat_q;
    ovf_d    = ovf_q | drop;
    done_d   = pop & is_last;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      beat_d   = is_last ? '0 : beat_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      beat_q   <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      beat_q   <= beat_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  // Data array needs no reset: reads are masked by tvalid. When full with a
  // simultaneous pop, wr_ptr == rd_ptr and the slot being popped is reused.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_pixel_i;
  end

  assign m_axis.tvalid = tvalid;
  assign m_axis.tdata  = tvalid ? 32'(mem_q[rd_ptr_q]) : 32'h0;
  assign m_axis.tlast  = tvalid & is_last;
  assign fill_level_o  = cnt_q;
  assign overflow_o    = ovf_q;
  assign frame_done_o  = done_q;

endmodule
